// File: rtl/gemm_tile_scheduler_pkg.sv
// Shared types and constants for the GEMM tile scheduler.
// State encoding, accumulator mode constants, watchdog default, M range helper.
package gemm_tile_scheduler_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LAUNCH     = 3'd1,
        S_WAIT_DONE  = 3'd2,
        S_DRAIN      = 3'd3,
        S_WAIT_DRAIN = 3'd4,
        S_FINISH     = 3'd5
    } sched_state_t;

    localparam logic ACC_MODE_OVERWRITE = 1'b0;
    localparam logic ACC_MODE_ACCUM     = 1'b1;

    localparam int WDOG_CYCLES_DEFAULT = 65535;

    // M must be in 1..2^aw so every row has an accumulator address.
    function automatic logic rows_in_range(
        input logic [31:0] m,
        input int unsigned aw
    );
        logic [32:0] lim;
        lim = 33'd1 << aw;
        return (m != 32'd0) && ({1'b0, m} <= lim);
    endfunction

endpackage

// File: rtl/gemm_tile_counter.sv
// Nested K/N tile index counter with last-tile flags.
// Ports: load (latch counts, zero indices), k_inc/k_clr/n_inc, k_idx/n_idx, k_last/n_last.
module gemm_tile_counter #(
    parameter int KT_WIDTH = 8,
    parameter int NT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [KT_WIDTH-1:0] kt_count,
    input  logic [NT_WIDTH-1:0] nt_count,
    input  logic                k_inc,
    input  logic                k_clr,
    input  logic                n_inc,
    output logic [KT_WIDTH-1:0] k_idx,
    output logic [NT_WIDTH-1:0] n_idx,
    output logic                k_last,
    output logic                n_last
);

    logic [KT_WIDTH-1:0] kt_q;
    logic [NT_WIDTH-1:0] nt_q;

    assign k_last = (k_idx == kt_q - KT_WIDTH'(1));
    assign n_last = (n_idx == nt_q - NT_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kt_q  <= '0;
            nt_q  <= '0;
            k_idx <= '0;
            n_idx <= '0;
        end else if (load) begin
            kt_q  <= kt_count;
            nt_q  <= nt_count;
            k_idx <= '0;
            n_idx <= '0;
        end else begin
            // Increments are gated by the last flags so indices never wrap.
            if (k_clr) begin
                k_idx <= '0;
            end else if (k_inc && !k_last) begin
                k_idx <= k_idx + KT_WIDTH'(1);
            end
            if (n_inc && !n_last) begin
                n_idx <= n_idx + NT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/gemm_tile_scheduler.sv
// Sequences the core over M x Kt x Nt tiles.
// Kt launches per N tile, then a drain.
module gemm_tile_scheduler
  import gemm_tile_scheduler_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int KT_WIDTH    = 8,
  parameter int NT_WIDTH    = 8,
  parameter int WDOG_CYCLES = WDOG_CYCLES_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [31:0]         cmd_m_rows,
  input  logic [KT_WIDTH-1:0] cmd_k_tiles,
  input  logic [NT_WIDTH-1:0] cmd_n_tiles,
  input  logic                abort,
  output logic                core_ap_start,
  output logic [31:0]         core_cfg_compute_cycles,
  output logic                core_cfg_acc_mode,
  input  logic                core_ap_done,
  input  logic                core_ap_idle,
  output logic                drain_start,
  output logic [ADDR_WIDTH:0] drain_rows,
  input  logic                drain_done,
  output logic [KT_WIDTH-1:0] tile_k_idx,
  output logic [NT_WIDTH-1:0] tile_n_idx,
  output logic                busy,
  output logic                done,
  output logic                err
);

  sched_state_t state;
  logic [31:0]  m_rows;
  logic         cmd_fire;
  logic         cmd_bad;
  logic         k_inc;
  logic         n_inc;
  logic         k_last;
  logic         n_last;

`ifdef GEMM_SCHED_WATCHDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
  logic [31:0] wdog_cnt;
  logic        wdog_hit;
  assign wdog_hit = (wdog_cnt == WDOG_LAST);
`endif

  assign cmd_ready = (state == S_IDLE);
  assign busy      = ~cmd_ready;

  assign core_cfg_compute_cycles = m_rows;
  assign drain_rows = m_rows[ADDR_WIDTH:0];

  assign cmd_fire = cmd_valid && cmd_ready && !abort;
  assign cmd_bad  = !rows_in_range(cmd_m_rows, ADDR_WIDTH)
                 || (cmd_k_tiles == '0)
                 || (cmd_n_tiles == '0);

  assign k_inc = !abort && (state == S_WAIT_DONE)
              && core_ap_done && !k_last;
  assign n_inc = !abort && (state == S_WAIT_DRAIN)
              && drain_done && !n_last;

  gemm_tile_counter #(
    .KT_WIDTH (KT_WIDTH),
    .NT_WIDTH (NT_WIDTH)
  ) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cmd_fire),
    .kt_count (cmd_k_tiles),
    .nt_count (cmd_n_tiles),
    .k_inc    (k_inc),
    .k_clr    (n_inc),
    .n_inc    (n_inc),
    .k_idx    (tile_k_idx),
    .n_idx    (tile_n_idx),
    .k_last   (k_last),
    .n_last   (n_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= S_IDLE;
      m_rows            <= '0;
      err               <= 1'b0;
      core_ap_start     <= 1'b0;
      core_cfg_acc_mode <= ACC_MODE_OVERWRITE;
      drain_start       <= 1'b0;
      done              <= 1'b0;
`ifdef GEMM_SCHED_WATCHDOG_EN
      wdog_cnt          <= '0;
`endif
    end else begin
      core_ap_start <= 1'b0;
      drain_start   <= 1'b0;
      done          <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (cmd_fire) begin
              m_rows <= cmd_m_rows;
              err    <= cmd_bad;
              if (!cmd_bad) begin
                state <= S_LAUNCH;
              end
            end
          end
          S_LAUNCH: begin
            if (core_ap_idle) begin
              core_ap_start     <= 1'b1;
              core_cfg_acc_mode <= (tile_k_idx != '0)
                ? ACC_MODE_ACCUM : ACC_MODE_OVERWRITE;
              state             <= S_WAIT_DONE;
`ifdef GEMM_SCHED_WATCHDOG_EN
              wdog_cnt          <= '0;
`endif
            end
          end
          S_WAIT_DONE: begin
            if (core_ap_done) begin
              state <= k_last ? S_DRAIN : S_LAUNCH;
            end
`ifdef GEMM_SCHED_WATCHDOG_EN
            else if (wdog_hit) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              wdog_cnt <= wdog_cnt + 32'd1;
            end
`endif
          end
          S_DRAIN: begin
            drain_start <= 1'b1;
            state       <= S_WAIT_DRAIN;
`ifdef GEMM_SCHED_WATCHDOG_EN
            wdog_cnt    <= '0;
`endif
          end
          S_WAIT_DRAIN: begin
            if (drain_done) begin
              state <= n_last ? S_FINISH : S_LAUNCH;
            end
`ifdef GEMM_SCHED_WATCHDOG_EN
            else if (wdog_hit) begin
              err   <= 1'b1;
              state <= S_IDLE;
            end else begin
              wdog_cnt <= wdog_cnt + 32'd1;
            end
`endif
          end
          S_FINISH: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Scoreboard bench for gemm_tile_scheduler.
// Randomized jobs, responders, tile-loop model.
module tb_gemm_tile_scheduler;

  localparam int AW = 8;
  localparam int EV_START = 0;
  localparam int EV_DRAIN = 1;
  localparam int EV_DONE  = 2;

  typedef struct {
    int kind;
    int acc;
    int k;
    int n;
    int rows;
  } ev_t;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_m_rows;
  logic [7:0]  cmd_k_tiles;
  logic [7:0]  cmd_n_tiles;
  logic        abort;
  logic        core_ap_start;
  logic [31:0] core_cfg_compute_cycles;
  logic        core_cfg_acc_mode;
  logic        core_ap_done;
  logic        core_ap_idle;
  logic        drain_start;
  logic [AW:0] drain_rows;
  logic        drain_done;
  logic [7:0]  tile_k_idx;
  logic [7:0]  tile_n_idx;
  logic        busy;
  logic        done;
  logic        err;

  gemm_tile_scheduler #(
    .WDOG_CYCLES (100)
  ) dut (
    .clk                     (clk),
    .rst_n                   (rst_n),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_m_rows              (cmd_m_rows),
    .cmd_k_tiles             (cmd_k_tiles),
    .cmd_n_tiles             (cmd_n_tiles),
    .abort                   (abort),
    .core_ap_start           (core_ap_start),
    .core_cfg_compute_cycles (core_cfg_compute_cycles),
    .core_cfg_acc_mode       (core_cfg_acc_mode),
    .core_ap_done            (core_ap_done),
    .core_ap_idle            (core_ap_idle),
    .drain_start             (drain_start),
    .drain_rows              (drain_rows),
    .drain_done              (drain_done),
    .tile_k_idx              (tile_k_idx),
    .tile_n_idx              (tile_n_idx),
    .busy                    (busy),
    .done                    (done),
    .err                     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  n_start = 0;
  int  n_drain = 0;
  int  n_done = 0;
  longint first_start_t = 0;
  longint t_acc = 0;

  bit  core_auto_en = 1;
  bit  drain_auto_en = 1;
  bit  stray_en = 0;
  bit  idle_block = 0;
  bit  flush = 0;
  bit  cbusy = 0;
  int  core_lat_min = 40;
  int  core_lat_max = 40;

  assign core_ap_idle = !cbusy && !idle_block;

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)",
               name, act, exp, $time);
    end
  endtask

  task automatic model_job(input int m, input int kt, input int nt,
                           output bit bad);
    ev_t e;
    bad = (m == 0) || (m > (1 << AW)) || (kt == 0) || (nt == 0);
    if (!bad) begin
      for (int n = 0; n < nt; n++) begin
        for (int k = 0; k < kt; k++) begin
          e = '{EV_START, (k > 0) ? 1 : 0, k, n, m};
          exp_q.push_back(e);
        end
        e = '{EV_DRAIN, 0, 0, n, m};
        exp_q.push_back(e);
      end
      e = '{EV_DONE, 0, 0, 0, 0};
      exp_q.push_back(e);
    end
  endtask

  task automatic take_event(input int kind);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d, expected none (t=%0t)",
               kind, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("FAIL event_kind: got %0d, expected %0d (t=%0t)",
                 kind, e.kind, $time);
      end else if (kind == EV_START) begin
        chk("acc_mode", core_cfg_acc_mode, e.acc);
        chk("start_k_idx", tile_k_idx, e.k);
        chk("start_n_idx", tile_n_idx, e.n);
        chk("compute_cycles", core_cfg_compute_cycles, e.rows);
      end else if (kind == EV_DRAIN) begin
        chk("drain_rows", drain_rows, e.rows);
        chk("drain_n_idx", tile_n_idx, e.n);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("busy_vs_ready", busy, !cmd_ready);
        if (core_ap_start) begin
          n_start++;
          if (first_start_t == 0) first_start_t = $time;
          take_event(EV_START);
        end
        if (drain_start) begin
          n_drain++;
          take_event(EV_DRAIN);
        end
        if (done) begin
          n_done++;
          take_event(EV_DONE);
          chk("err_at_done", err, 0);
        end
      end
    end
  end

  initial begin
    int cd;
    cd = 0;
    core_ap_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      core_ap_done = 1'b0;
      if (!rst_n || flush) begin
        cbusy = 0;
      end else if (core_ap_start) begin
        cbusy = 1;
        cd = int'($urandom_range(core_lat_max, core_lat_min));
      end else if (cbusy && core_auto_en) begin
        cd--;
        if (cd <= 0) begin
          core_ap_done = 1'b1;
          cbusy = 0;
        end
      end else if (!cbusy && stray_en
                   && $urandom_range(15, 0) == 0) begin
        core_ap_done = 1'b1;
      end
    end
  end

  initial begin
    int  dd;
    bit  dpend;
    dd = 0;
    dpend = 0;
    drain_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      drain_done = 1'b0;
      if (!rst_n || flush) begin
        dpend = 0;
      end else if (drain_start) begin
        dpend = 1;
        dd = int'($urandom_range(8, 1));
      end else if (dpend && drain_auto_en) begin
        dd--;
        if (dd <= 0) begin
          drain_done = 1'b1;
          dpend = 0;
        end
      end else if (!dpend && stray_en
                   && $urandom_range(15, 0) == 0) begin
        drain_done = 1'b1;
      end
    end
  end

  task automatic send_cmd(input int m, input int kt, input int nt,
                          output bit bad);
    int guard;
    guard = 0;
    @(posedge clk);
    #2;
    while (!cmd_ready && guard < 20000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    chk("cmd_ready_before_send", cmd_ready, 1);
    cmd_m_rows  = 32'(m);
    cmd_k_tiles = 8'(kt);
    cmd_n_tiles = 8'(nt);
    cmd_valid   = 1'b1;
    first_start_t = 0;
    model_job(m, kt, nt, bad);
    @(posedge clk);
    t_acc = $time;
    #2;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int c;
    c = 0;
    while ((busy || exp_q.size() != 0) && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (busy || exp_q.size() != 0) begin
      errors++;
      $display("FAIL job_timeout: busy=%0d pending=%0d, expected 0 and 0",
               busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_starts(input int target, input int budget);
    int c;
    c = 0;
    while (n_start < target && c < budget) begin
      @(posedge clk);
      #2;
      c++;
    end
    chk("start_count_reached", n_start, target);
  endtask

  task automatic flush_resp();
    @(posedge clk);
    #2;
    flush = 1;
    @(posedge clk);
    #2;
    flush = 0;
  endtask

  initial begin
    bit bad;
    int m;
    int kt;
    int nt;
    int s0;
    int exp_starts;
    int exp_drains;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_m_rows = '0;
    cmd_k_tiles = '0;
    cmd_n_tiles = '0;
    abort = 1'b0;
    #23;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ap_start", core_ap_start, 0);
    chk("rst_drain_start", drain_start, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_acc_mode", core_cfg_acc_mode, 0);
    chk("rst_cycles", core_cfg_compute_cycles, 0);
    chk("rst_drain_rows", drain_rows, 0);
    chk("rst_k_idx", tile_k_idx, 0);
    chk("rst_n_idx", tile_n_idx, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    n_start = 0; n_drain = 0; n_done = 0;
    send_cmd(197, 3, 2, bad);
    wait_idle(5000);
    chk("first_start_latency", first_start_t - t_acc, 15);
    chk("job1_starts", n_start, 3 * 2);
    chk("job1_drains", n_drain, 2);
    chk("job1_dones", n_done, 1);
    chk("job1_err", err, 0);

    core_lat_min = 1;
    core_lat_max = 12;
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: send_cmd(0, 1, 1, bad);
        1: send_cmd((1 << AW) + 1, 1, 1, bad);
        2: send_cmd(5, 0, 1, bad);
        default: send_cmd(5, 1, 0, bad);
      endcase
      chk("reject_err", err, 1);
      chk("reject_ready", cmd_ready, 1);
      chk("reject_busy", busy, 0);
      repeat (4) @(posedge clk);
    end
    send_cmd(1 << AW, 1, 1, bad);
    chk("accept_clears_err", err, 0);
    chk("accept_busy", busy, 1);
    wait_idle(5000);

    idle_block = 1;
    send_cmd(20, 2, 1, bad);
    repeat (10) @(posedge clk);
    #2;
    idle_block = 0;
    wait_idle(5000);
    chk("idle_hold_latency", first_start_t - t_acc, 115);

    stray_en = 1;
    n_start = 0; n_drain = 0;
    exp_starts = 0; exp_drains = 0;
    for (int j = 0; j < 10; j++) begin
      m  = int'($urandom_range(1 << AW, 1));
      kt = int'($urandom_range(4, 1));
      nt = int'($urandom_range(3, 1));
      if ($urandom_range(5, 0) == 0) m = 0;
      if ($urandom_range(7, 0) == 0) m = (1 << AW) + 7;
      idle_block = ($urandom_range(3, 0) == 0);
      send_cmd(m, kt, nt, bad);
      idle_block = 0;
      if (!bad) begin
        exp_starts += kt * nt;
        exp_drains += nt;
      end
      wait_idle(5000);
      chk("rand_err", err, bad ? 1 : 0);
    end
    chk("rand_starts", n_start, exp_starts);
    chk("rand_drains", n_drain, exp_drains);
    stray_en = 0;

    drain_auto_en = 0;
    s0 = n_drain;
    send_cmd(33, 1, 2, bad);
    for (int c = 0; c < 2000 && n_drain == s0; c++) begin
      @(posedge clk);
      #2;
    end
    chk("abort_drain_seen", n_drain, s0 + 1);
    drain_done = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #2;
    drain_done = 1'b0;
    abort = 1'b0;
    exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_n_idx", tile_n_idx, 0);
    chk("abort_err", err, 0);
    chk("abort_done", done, 0);
    repeat (5) @(posedge clk);
    drain_auto_en = 1;
    flush_resp();

    core_auto_en = 0;
    s0 = n_start;
    send_cmd(40, 3, 1, bad);
    wait_starts(s0 + 1, 500);
    core_auto_en = 1;
    wait_starts(s0 + 3, 500);
    abort = 1'b1;
    @(posedge clk);
    #2;
    abort = 1'b0;
    exp_q.delete();
    chk("abort2_busy", busy, 0);
    chk("abort2_k_idx", tile_k_idx, 2);
    chk("abort2_err", err, 0);
    flush_resp();

    core_auto_en = 0;
    s0 = n_start;
    send_cmd(50, 2, 2, bad);
    wait_starts(s0 + 1, 500);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ap_start", core_ap_start, 0);
    chk("midrst_drain_start", drain_start, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_k_idx", tile_k_idx, 0);
    exp_q.delete();
    core_auto_en = 1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    n_start = 0; n_drain = 0; n_done = 0;
    send_cmd(64, 2, 2, bad);
    wait_idle(5000);
    chk("postrst_starts", n_start, 4);
    chk("postrst_drains", n_drain, 2);
    chk("postrst_dones", n_done, 1);

`ifdef GEMM_SCHED_WATCHDOG_EN
    begin
      longint t_err;
      core_auto_en = 0;
      t_err = 0;
      send_cmd(10, 1, 1, bad);
      for (int c = 0; c < 400 && t_err == 0; c++) begin
        @(negedge clk);
        if (err) t_err = $time;
      end
      chk("wdog_err", err, 1);
      chk("wdog_cycles", (t_err - first_start_t) / 10, 100);
      chk("wdog_busy", busy, 0);
      exp_q.delete();
      core_auto_en = 1;
      flush_resp();
    end
`endif

    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
